valu_wb_tracker: RTL and testbench

- Issue/writeback companion to vector_alu. It drives the issue side of the fixed-latency vector ALU and captures each result at the exact cycle the ALU produces it.
- vector_alu has no output valid; this block tags every issued op with its destination and result kind, then catches vout/rout LATENCY cycles later.
- Results are queued in a small FIFO and presented to the register-file writeback port with a valid/ready handshake.
- Credit-based issue backpressure guarantees the FIFO never overflows.

---
 rtl/valu_pkg.sv | 53 +++++
 rtl/valu_wb_tracker_if.sv | 34 +++
 rtl/valu_wb_fifo.sv | 80 ++++++++
 rtl/valu_wb_tracker.sv | 155 +++++++++++++++
 tb/tb_valu_wb_tracker.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared opcodes, op classification and types for the vector ALU writeback tracker
//
// Purpose : opcode constants for vector_alu, op-class helpers, and the tag,
//           vector and writeback-entry types shared by the tracker files.
// Contents: VALU_TAG_W, OP_* opcodes, is_legal_op(), is_scalar_op(),
//           vec_t, valu_tag_t, valu_wb_t.
package valu_pkg;

  localparam int VALU_TAG_W = 5;

  localparam logic [4:0] OP_VADD    = 5'h03;
  localparam logic [4:0] OP_VSUB    = 5'h04;
  localparam logic [4:0] OP_VMUL    = 5'h05;
  localparam logic [4:0] OP_VDOT    = 5'h06;
  localparam logic [4:0] OP_VDOTA   = 5'h07;
  localparam logic [4:0] OP_VINDX   = 5'h08;
  localparam logic [4:0] OP_VREDUCE = 5'h09;
  localparam logic [4:0] OP_VDIV    = 5'h0A;
  localparam logic [4:0] OP_VSQRT   = 5'h0B;
  localparam logic [4:0] OP_VABS    = 5'h0C;
  localparam logic [4:0] OP_VNEG    = 5'h0D;
  localparam logic [4:0] OP_VRELU   = 5'h0E;
  localparam logic [4:0] OP_VSCALE  = 5'h0F;
  localparam logic [4:0] OP_VFMA    = 5'h10;
  localparam logic [4:0] OP_VMAX    = 5'h11;
  localparam logic [4:0] OP_VMIN    = 5'h12;

  typedef logic [3:0][31:0] vec_t;

  typedef struct packed {
    logic                  valid;
    logic                  scalar;
    logic [VALU_TAG_W-1:0] dst;
  } valu_tag_t;

  typedef struct packed {
    logic                  scalar;
    logic [VALU_TAG_W-1:0] dst;
    vec_t                  vdata;
    logic [31:0]           sdata;
  } valu_wb_t;

  // The legal opcodes form one contiguous range.
  function automatic logic is_legal_op(input logic [4:0] op);
    return (op >= OP_VADD) && (op <= OP_VMIN);
  endfunction

  // Scalar-result ops (dot products, index, reduce) are contiguous too.
  function automatic logic is_scalar_op(input logic [4:0] op);
    return (op >= OP_VDOT) && (op <= OP_VREDUCE);
  endfunction

endpackage

// File: rtl/valu_wb_tracker_if.sv
// rtl/valu_wb_tracker_if.sv - issue and writeback handshake bundle of the vector ALU writeback tracker
//
// Purpose : groups the issue-side and register-file writeback handshakes.
// Signals : issue_valid/issue_ready/issue_op/issue_dst  (op offer)
//           wb_valid/wb_ready/wb_scalar/wb_dst/wb_vdata/wb_sdata  (result)
// Modports: slave  - the tracker (accepts ops, produces results)
//           master - the issuer / register file side
interface valu_wb_tracker_if #(
  parameter int TAG_W = 5
) ();

  logic               issue_valid;
  logic               issue_ready;
  logic [4:0]         issue_op;
  logic [TAG_W-1:0]   issue_dst;

  logic               wb_valid;
  logic               wb_ready;
  logic               wb_scalar;
  logic [TAG_W-1:0]   wb_dst;
  valu_pkg::vec_t     wb_vdata;
  logic [31:0]        wb_sdata;

  modport slave (
    input  issue_valid, issue_op, issue_dst, wb_ready,
    output issue_ready, wb_valid, wb_scalar, wb_dst, wb_vdata, wb_sdata
  );

  modport master (
    output issue_valid, issue_op, issue_dst, wb_ready,
    input  issue_ready, wb_valid, wb_scalar, wb_dst, wb_vdata, wb_sdata
  );

endinterface

// File: rtl/valu_wb_fifo.sv
// rtl/valu_wb_fifo.sv - DEPTH-entry circular result FIFO for the vector ALU writeback tracker
//
// Purpose : holds captured ALU results until the register file accepts them.
// Ports   : clk, rst (sync active-high), clear (drop all entries),
//           push/push_data, pop, head (zero when empty), empty, full, count.
module valu_wb_fifo
  import valu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  valu_wb_t         push_data,
  input  logic             pop,
  output valu_wb_t         head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  valu_wb_t         mem_q [DEPTH];
  valu_wb_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign do_pop = pop && !empty;
  // Payload reads as zero whenever nothing is queued.
  assign head   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    // Storage needs no reset: head is masked while empty.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/valu_wb_tracker.sv
// rtl/valu_wb_tracker.sv - issue/writeback companion for the fixed-latency vector ALU
//
// Purpose : issues ops to vector_alu under credit control, tags each op, and
//           captures vout/rout exactly LATENCY cycles after issue into a
//           result FIFO presented on a valid/ready writeback port.
// Ports   : clk, rst (sync active-high), flush (drop everything in flight)
//           bus        - issue and writeback handshakes (slave modport)
//           alu_en     - registered enable to vector_alu (legal accepted op)
//           alu_op     - registered opcode to vector_alu
//           illegal_op - one-cycle pulse after an illegal op is accepted
//           alu_vout, alu_rout - vector_alu results
//           inflight   - ops in the tag pipeline plus results queued
module valu_wb_tracker
  import valu_pkg::*;
#(
  parameter  int LATENCY = 9,   // must be at least 1
  parameter  int DEPTH   = 4,
  parameter  int TAG_W   = 5,
  localparam int IF_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  valu_wb_tracker_if.slave  bus,
  output logic              alu_en,
  output logic [4:0]        alu_op,
  output logic              illegal_op,
  input  vec_t              alu_vout,
  input  logic [31:0]       alu_rout,
  output logic [IF_W-1:0]   inflight
);

  valu_tag_t       pipe_q [LATENCY];
  valu_tag_t       pipe_d [LATENCY];
  logic [IF_W-1:0] inflight_q, inflight_d;
  logic            alu_en_q, alu_en_d;
  logic [4:0]      alu_op_q, alu_op_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            accept_legal;
  logic            wb_fire;
  logic            push;
  valu_wb_t        push_data;
  valu_wb_t        head;
  logic            fifo_empty;
  logic            fifo_full;
  logic [IF_W-1:0] fifo_count;

  // Credits cover both the tag pipeline and the FIFO, so a capture can never
  // find the FIFO full.
  assign bus.issue_ready = !flush && (inflight_q < IF_W'(DEPTH));
  assign accept          = bus.issue_valid && bus.issue_ready;
  assign accept_legal    = accept && is_legal_op(bus.issue_op);
  assign wb_fire         = bus.wb_valid && bus.wb_ready;

  always_comb begin
    pipe_d[0] = '0;
    if (accept_legal) begin
      pipe_d[0].valid  = 1'b1;
      pipe_d[0].scalar = is_scalar_op(bus.issue_op);
      pipe_d[0].dst    = VALU_TAG_W'(bus.issue_dst);
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    inflight_d = inflight_q;
    case ({accept_legal, wb_fire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    // The ALU sees en/op together in the cycle after acceptance.
    alu_en_d  = accept_legal;
    alu_op_d  = accept_legal ? bus.issue_op : alu_op_q;
    illegal_d = accept && !is_legal_op(bus.issue_op);

    // flush wins over any simultaneous issue or writeback handshake.
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_d[i] = '0;
      end
      inflight_d = '0;
      alu_en_d   = 1'b0;
      alu_op_d   = '0;
      illegal_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      inflight_q <= '0;
      alu_en_q   <= 1'b0;
      alu_op_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      pipe_q     <= pipe_d;
      inflight_q <= inflight_d;
      alu_en_q   <= alu_en_d;
      alu_op_q   <= alu_op_d;
      illegal_q  <= illegal_d;
    end
  end

  // The last tag stage lines up with the edge at which the ALU result is valid.
  always_comb begin
    push_data        = '0;
    push_data.scalar = pipe_q[LATENCY-1].scalar;
    push_data.dst    = pipe_q[LATENCY-1].dst;
    if (pipe_q[LATENCY-1].scalar) begin
      push_data.sdata = alu_rout;
    end else begin
      push_data.vdata = alu_vout;
    end
  end

  assign push = pipe_q[LATENCY-1].valid && !flush;

  valu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (wb_fire),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign bus.wb_valid  = !fifo_empty;
  assign bus.wb_scalar = head.scalar;
  assign bus.wb_dst    = TAG_W'(head.dst);
  assign bus.wb_vdata  = head.vdata;
  assign bus.wb_sdata  = head.sdata;

  assign alu_en     = alu_en_q;
  assign alu_op     = alu_op_q;
  assign illegal_op = illegal_q;
  assign inflight   = inflight_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && fifo_full));
  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (rst)
    inflight_q >= fifo_count);

endmodule

// File: tb/tb_valu_wb_tracker.sv
// tb/tb_valu_wb_tracker.sv - self-checking bench for valu_wb_tracker
module tb_valu_wb_tracker;
  import valu_pkg::*;

  localparam int LAT   = 9;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic        s;
    logic [4:0]  d;
    logic [127:0] v;
    logic [31:0] r;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       alu_en;
  logic [4:0] alu_op;
  logic       illegal_op;
  vec_t       alu_vout;
  logic [31:0] alu_rout;
  logic [2:0] inflight;

  valu_wb_tracker_if #(.TAG_W(TAG_W)) bus ();

  valu_wb_tracker #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .alu_vout   (alu_vout),
    .alu_rout   (alu_rout),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         chk_en = 1'b0;
  res_t         fifo_m [$];
  res_t         pend_m [int];
  logic [159:0] sched [int];
  int           inflight_m = 0;
  logic         illegal_m = 1'b0;
  logic         alu_en_m = 1'b0;
  logic [4:0]   alu_op_m = '0;
  logic [127:0] cur_vout = '0;
  logic [31:0]  cur_rout = '0;
  int           popped [$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: ops become results exactly LAT edges after acceptance, results
  // leave in order on handshakes, credits count everything not yet written back.
  always @(posedge clk) begin
    logic acc, legal, pop;
    res_t e;
    cyc++;
    acc   = bus.issue_valid && !flush && (inflight_m < DEPTH);
    legal = (bus.issue_op >= 5'h03) && (bus.issue_op <= 5'h12);
    pop   = (fifo_m.size() > 0) && bus.wb_ready;
    if (rst || flush) begin
      fifo_m.delete();
      pend_m.delete();
      inflight_m = 0;
      illegal_m  = 1'b0;
      alu_en_m   = 1'b0;
      alu_op_m   = '0;
    end else begin
      if (pop) begin
        void'(fifo_m.pop_front());
        inflight_m--;
      end
      illegal_m = acc && !legal;
      alu_en_m  = acc && legal;
      if (acc && legal) begin
        alu_op_m = bus.issue_op;
        inflight_m++;
        e.s = (bus.issue_op >= 5'h06) && (bus.issue_op <= 5'h09);
        e.d = bus.issue_dst;
        e.v = e.s ? 128'd0 : cur_vout;
        e.r = e.s ? cur_rout : 32'd0;
        pend_m[cyc + LAT] = e;
        sched[cyc + LAT]  = {cur_vout, cur_rout};
      end
      if (pend_m.exists(cyc)) begin
        fifo_m.push_back(pend_m[cyc]);
        pend_m.delete(cyc);
      end
    end
  end

  // Stub ALU: correct values only in the cycle the result is due, noise otherwise.
  always @(negedge clk) begin
    if (sched.exists(cyc + 1)) begin
      {alu_vout, alu_rout} = sched[cyc + 1];
    end else begin
      alu_vout = {$urandom, $urandom, $urandom, $urandom};
      alu_rout = $urandom;
    end
  end

  // Per-cycle comparison against the model, plus DUT pop-order log.
  always @(negedge clk) begin
    res_t h;
    if (chk_en) begin
      h = (fifo_m.size() > 0) ? fifo_m[0] : '0;
      check("wb_valid", bus.wb_valid, fifo_m.size() > 0);
      check("wb_scalar", bus.wb_scalar, h.s);
      check("wb_dst", bus.wb_dst, h.d);
      check("wb_vdata", bus.wb_vdata, h.v);
      check("wb_sdata", bus.wb_sdata, h.r);
      check("inflight", inflight, inflight_m);
      check("issue_ready", bus.issue_ready, !flush && (inflight_m < DEPTH));
      check("illegal_op", illegal_op, illegal_m);
      check("alu_en", alu_en, alu_en_m);
      check("alu_op", alu_op, alu_op_m);
    end
    if (bus.wb_valid && bus.wb_ready && !flush && !rst) popped.push_back(int'(bus.wb_dst));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] dst,
                       input logic [127:0] v, input logic [31:0] r, output int edge_n);
    logic acc;
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_dst   = dst;
    cur_vout        = v;
    cur_rout        = r;
    edge_n          = -1;
    for (int i = 0; i < 200; i++) begin
      acc = bus.issue_ready;
      step();
      if (acc) begin
        edge_n = cyc;
        break;
      end
    end
    bus.issue_valid = 1'b0;
    check("issue_accepted", edge_n >= 0, 1'b1);
  endtask

  task automatic wait_wb(input int maxc, output int edge_n);
    edge_n = -1;
    for (int i = 0; i < maxc; i++) begin
      if (bus.wb_valid) begin
        edge_n = cyc;
        break;
      end
      step();
    end
    check("wb_arrived", edge_n >= 0, 1'b1);
  endtask

  localparam logic [4:0] T_OP  [10] = '{5'h01, 5'h02, 5'h03, 5'h05, 5'h06, 5'h09, 5'h0A, 5'h12, 5'h13, 5'h1F};
  localparam logic       T_ILL [10] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
  localparam logic       T_SCL [10] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e0, e1, seen, base, scl;
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
    bus.issue_dst   = '0;
    bus.wb_ready    = 1'b1;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_inflight", inflight, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_issue_ready", bus.issue_ready, 1);
    check("rst_alu_en", alu_en, 0);

    // Single vadd
    issue(5'h03, 5'd5, {4{32'h40800000}}, 32'hdeadbeef, e0);
    check("vadd_alu_en", alu_en, 1);
    check("vadd_alu_op", alu_op, 5'h03);
    check("vadd_inflight", inflight, 1);
    wait_wb(30, e1);
    check("vadd_latency", e1 - e0, 9);
    check("vadd_scalar", bus.wb_scalar, 0);
    check("vadd_dst", bus.wb_dst, 5);
    check("vadd_vdata", bus.wb_vdata, {4{32'h40800000}});
    repeat (3) step();

    // Scalar vdot
    issue(5'h06, 5'd2, {4{32'h12345678}}, 32'h41800000, e0);
    wait_wb(30, e1);
    check("vdot_latency", e1 - e0, 9);
    check("vdot_scalar", bus.wb_scalar, 1);
    check("vdot_sdata", bus.wb_sdata, 32'h41800000);
    check("vdot_dst", bus.wb_dst, 2);
    check("vdot_vdata", bus.wb_vdata, 128'd0);
    repeat (3) step();

    // Credit stall
    bus.wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issue(5'h03, 5'(i), {4{32'(i)}}, 32'd0, e0);
    check("stall_ready", bus.issue_ready, 0);
    check("stall_inflight", inflight, 4);
    repeat (12) step();
    check("stall_ready_hold", bus.issue_ready, 0);
    base = popped.size();
    bus.wb_ready = 1'b1;
    step();
    check("stall_ready_after_pop", bus.issue_ready, 1);
    check("stall_inflight_after_pop", inflight, 3);
    repeat (5) step();
    for (int i = 0; i < 4; i++)
      check("stall_order", (popped.size() > base + i) ? popped[base + i] : -1, i + 1);

    // Twelve ops streaming through the credit window, FIFO wraps
    base = popped.size();
    for (int i = 0; i < 12; i++)
      issue((i % 3 == 1) ? 5'h07 : 5'h10, 5'(i + 8), {4{32'(i * 7 + 1)}}, 32'(i * 13 + 5), e0);
    repeat (25) step();
    for (int i = 0; i < 12; i++)
      check("stream_order", (popped.size() > base + i) ? popped[base + i] : -1, i + 8);
    check("stream_drained", inflight, 0);

    // Opcode class boundaries, including illegal ops
    for (int k = 0; k < 10; k++) begin
      issue(T_OP[k], 5'(k), {4{32'(k + 100)}}, 32'(k + 200), e0);
      check("cls_illegal_pulse", illegal_op, T_ILL[k]);
      check("cls_alu_en", alu_en, !T_ILL[k]);
      check("cls_inflight", inflight, T_ILL[k] ? 0 : 1);
      step();
      check("cls_illegal_clear", illegal_op, 0);
      seen = 0;
      scl  = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.wb_valid) begin
          seen++;
          scl = int'(bus.wb_scalar);
        end
        step();
      end
      check("cls_wb_count", seen, T_ILL[k] ? 0 : 1);
      if (!T_ILL[k]) check("cls_scalar", scl, T_SCL[k]);
    end

    // Flush mid-flight, then rst mid-flight
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) issue(5'h04, 5'(20 + i), {4{32'habcd0000 + 32'(i)}}, 32'd0, e0);
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      step();
      flush = 1'b0;
      rst   = 1'b0;
      check("flush_inflight", inflight, 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.wb_valid || inflight != 0) seen++;
        step();
      end
      check("flush_quiet", seen, 0);
      issue(5'h03, 5'd7, {4{32'h3f800000}}, 32'd0, e0);
      wait_wb(30, e1);
      check("flush_next_latency", e1 - e0, 9);
      check("flush_next_dst", bus.wb_dst, 7);
      check("flush_next_vdata", bus.wb_vdata, {4{32'h3f800000}});
      repeat (3) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
